// File: rtl/uart_cmd_master_pkg.sv
// Shared encodings, frame constants and per-command sizing for the UART command master.
package uart_cmd_master_pkg;

    typedef enum logic [1:0] {
        CmdRegWr  = 2'd0,
        CmdRegRd  = 2'd1,
        CmdAluOp  = 2'd2,
        CmdAluNop = 2'd3
    } cmd_type_e;

    localparam logic [7:0] HdrRegWr  = 8'hAA;
    localparam logic [7:0] HdrRegRd  = 8'hBB;
    localparam logic [7:0] HdrAluOp  = 8'hCC;
    localparam logic [7:0] HdrAluNop = 8'hDD;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitHi,
        StWaitLo,
        StWaitRsp,
        StDone
    } state_e;

    function automatic logic [2:0] tx_bytes(input cmd_type_e t);
        unique case (t)
            CmdRegWr:  return 3'd3;
            CmdRegRd:  return 3'd2;
            CmdAluOp:  return 3'd4;
            CmdAluNop: return 3'd2;
        endcase
    endfunction

    function automatic logic [1:0] rsp_bytes(input cmd_type_e t);
        unique case (t)
            CmdRegWr:  return 2'd0;
            CmdRegRd:  return 2'd1;
            CmdAluOp:  return 2'd2;
            CmdAluNop: return 2'd2;
        endcase
    endfunction

    function automatic logic [7:0] frame_byte(input cmd_type_e t, input logic [1:0] idx,
                                              input logic [3:0] addr, input logic [7:0] op_a,
                                              input logic [7:0] op_b, input logic [3:0] fun);
        logic [7:0] b;
        b = 8'h00;
        unique case (t)
            CmdRegWr: begin
                case (idx)
                    2'd0:    b = HdrRegWr;
                    2'd1:    b = {4'h0, addr};
                    default: b = op_a;
                endcase
            end
            CmdRegRd:  b = (idx == 2'd0) ? HdrRegRd : {4'h0, addr};
            CmdAluOp: begin
                case (idx)
                    2'd0:    b = HdrAluOp;
                    2'd1:    b = op_a;
                    2'd2:    b = op_b;
                    default: b = {4'h0, fun};
                endcase
            end
            CmdAluNop: b = (idx == 2'd0) ? HdrAluNop : {4'h0, fun};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Saturating elapsed-cycle counter; restart loads 1 so the count equals cycles since restart.
module uart_cmd_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic CLK,
    input  logic RST,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] MaxCnt  = W'(LIMIT);
    localparam logic [W-1:0] LastCnt = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = W'(1);
        end else if (enable && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Asserted in the cycle whose closing edge brings the count to LIMIT.
    assign expired = enable && !restart && (cnt_q >= LastCnt);

endmodule

// File: rtl/uart_cmd_master.sv
// Serialises one command into UART frame bytes and assembles the response or flags a timeout.
module uart_cmd_master #(
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter int unsigned BUSY_GUARD  = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [3:0]  cmd_addr,
    input  logic [7:0]  cmd_op_a,
    input  logic [7:0]  cmd_op_b,
    input  logic [3:0]  cmd_fun,
    output logic [7:0]  TX_P_Data,
    output logic        TX_D_VLD,
    input  logic        Busy,
    input  logic [7:0]  RX_P_Data,
    input  logic        RX_D_VLD,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_timeout
);
    import uart_cmd_master_pkg::*;

    state_e      state_q, state_d;
    cmd_type_e   type_q;
    logic [3:0]  addr_q, fun_q;
    logic [7:0]  op_a_q, op_b_q, tx_data_q;
    logic [1:0]  byte_idx_q;
    logic        rsp_idx_q;
    logic [15:0] rsp_buf_q, rsp_buf_d, rsp_data_q;
    logic        rsp_timeout_q;

    logic        accept, tx_strobe, last_tx, last_rsp, rx_take, no_rsp;
    logic        guard_en, guard_exp, tmo_en, tmo_restart, tmo_exp;
    logic [7:0]  cur_byte;
    logic [15:0] rsp_final;

    assign accept    = cmd_valid && (state_q == StIdle);
    assign tx_strobe = (state_q == StLoad) && !Busy;
    assign last_tx   = ({1'b0, byte_idx_q} == (tx_bytes(type_q) - 3'd1));
    assign last_rsp  = ({1'b0, rsp_idx_q} == (rsp_bytes(type_q) - 2'd1));
    assign no_rsp    = (rsp_bytes(type_q) == 2'd0);
    assign rx_take   = (state_q == StWaitRsp) && RX_D_VLD;
    assign cur_byte  = frame_byte(type_q, byte_idx_q, addr_q, op_a_q, op_b_q, fun_q);

    assign guard_en    = (state_q == StWaitHi);
    assign tmo_en      = (state_q == StWaitRsp);
    assign tmo_restart = ((state_q == StWaitLo) && !Busy && last_tx && !no_rsp) || rx_take;

    uart_cmd_timer #(.LIMIT(BUSY_GUARD)) u_guard (
        .CLK     (CLK),
        .RST     (RST),
        .restart (tx_strobe),
        .enable  (guard_en),
        .expired (guard_exp)
    );

    uart_cmd_timer #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .CLK     (CLK),
        .RST     (RST),
        .restart (tmo_restart),
        .enable  (tmo_en),
        .expired (tmo_exp)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = StLoad;
            StLoad:    if (!Busy) state_d = StWaitHi;
            StWaitHi:  if (Busy || guard_exp) state_d = StWaitLo;
            StWaitLo: begin
                if (!Busy) begin
                    if (!last_tx)    state_d = StLoad;
                    else if (no_rsp) state_d = StDone;
                    else             state_d = StWaitRsp;
                end
            end
            StWaitRsp: begin
                // A byte arriving on the expiry cycle takes priority over the timeout.
                if (RX_D_VLD) begin
                    if (last_rsp) state_d = StDone;
                end else if (tmo_exp) begin
                    state_d = StDone;
                end
            end
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready   = (state_q == StIdle);
        TX_D_VLD    = tx_strobe;
        TX_P_Data   = tx_strobe ? cur_byte : tx_data_q;
        rsp_valid   = (state_q == StDone);
        rsp_data    = rsp_data_q;
        rsp_timeout = rsp_timeout_q;
    end

    always_comb begin
        rsp_buf_d = rsp_buf_q;
        if (rx_take) begin
            if (rsp_idx_q) rsp_buf_d[15:8] = RX_P_Data;
            else           rsp_buf_d[7:0]  = RX_P_Data;
        end
        unique case (type_q)
            CmdRegWr:  rsp_final = 16'h0000;
            CmdRegRd:  rsp_final = {8'h00, rsp_buf_d[7:0]};
            default:   rsp_final = rsp_buf_d;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            type_q        <= CmdRegWr;
            addr_q        <= '0;
            fun_q         <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            tx_data_q     <= '0;
            byte_idx_q    <= '0;
            rsp_idx_q     <= 1'b0;
            rsp_buf_q     <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                type_q     <= cmd_type_e'(cmd_type);
                addr_q     <= cmd_addr;
                fun_q      <= cmd_fun;
                op_a_q     <= cmd_op_a;
                op_b_q     <= cmd_op_b;
                byte_idx_q <= '0;
                rsp_idx_q  <= 1'b0;
                rsp_buf_q  <= '0;
            end else begin
                rsp_buf_q <= rsp_buf_d;
            end
            if (tx_strobe) tx_data_q <= cur_byte;
            if ((state_q == StWaitLo) && !Busy && !last_tx) byte_idx_q <= byte_idx_q + 2'd1;
            if (rx_take) rsp_idx_q <= ~rsp_idx_q;
            if ((state_d == StDone) && (state_q != StDone)) begin
                rsp_data_q    <= rsp_final;
                rsp_timeout_q <= (state_q == StWaitRsp) && !RX_D_VLD;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed bench for uart_cmd_master with a Busy model and hand-computed frames and responses.
module tb_uart_cmd_master;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_type = 2'd0;
    logic [3:0]  cmd_addr = 4'h0;
    logic [7:0]  cmd_op_a = 8'h00;
    logic [7:0]  cmd_op_b = 8'h00;
    logic [3:0]  cmd_fun = 4'h0;
    logic        Busy = 1'b0;
    logic [7:0]  RX_P_Data = 8'h00;
    logic        RX_D_VLD = 1'b0;
    logic        cmd_ready, TX_D_VLD, rsp_valid, rsp_timeout;
    logic [7:0]  TX_P_Data;
    logic [15:0] rsp_data;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [7:0]  tx_q[$];
    int          rsp_cnt = 0;
    logic [15:0] rsp_d_cap = 16'h0;
    logic        rsp_to_cap = 1'b0;
    int          rsp_cyc = 0;
    int          rx_cyc = 0;
    bit          strobe_flag = 0;
    bit          busy_force = 0;
    int          busy_len = 3;
    int          busy_cnt = 0;

    uart_cmd_master #(.TIMEOUT_CYC(100), .BUSY_GUARD(15)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_type    (cmd_type),
        .cmd_addr    (cmd_addr),
        .cmd_op_a    (cmd_op_a),
        .cmd_op_b    (cmd_op_b),
        .cmd_fun     (cmd_fun),
        .TX_P_Data   (TX_P_Data),
        .TX_D_VLD    (TX_D_VLD),
        .Busy        (Busy),
        .RX_P_Data   (RX_P_Data),
        .RX_D_VLD    (RX_D_VLD),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout)
    );

    always #5 CLK = ~CLK;

    // Monitor: everything the DUT drives is sampled mid-cycle.
    initial forever begin
        @(negedge CLK);
        cyc = cyc + 1;
        if (TX_D_VLD) begin
            tx_q.push_back(TX_P_Data);
            strobe_flag = 1;
        end
        if (RX_D_VLD) rx_cyc = cyc;
        if (rsp_valid) begin
            rsp_cnt    = rsp_cnt + 1;
            rsp_d_cap  = rsp_data;
            rsp_to_cap = rsp_timeout;
            rsp_cyc    = cyc;
        end
    end

    // Transmitter model: Busy rises the cycle after a strobe and stays high busy_len cycles.
    initial forever begin
        @(posedge CLK);
        #1;
        if (strobe_flag) begin
            strobe_flag = 0;
            busy_cnt = busy_len;
        end
        if (busy_force) begin
            Busy = 1'b1;
        end else if (busy_cnt > 0) begin
            Busy = 1'b1;
            busy_cnt = busy_cnt - 1;
        end else begin
            Busy = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] x,
                            input logic [7:0] y, input logic [3:0] f);
        cmd_type  = t;
        cmd_addr  = a;
        cmd_op_a  = x;
        cmd_op_b  = y;
        cmd_fun   = f;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_type  = ~t;
        cmd_addr  = ~a;
        cmd_op_a  = ~x;
        cmd_op_b  = ~y;
        cmd_fun   = ~f;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        RX_P_Data = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
    endtask

    task automatic wait_tx(input int n, output bit ok);
        for (int i = 0; i < 2000 && tx_q.size() < n; i++) tick();
        ok = (tx_q.size() >= n);
    endtask

    task automatic wait_rsp(input int base, input int limit, output bit ok);
        for (int i = 0; i < limit && rsp_cnt == base; i++) tick();
        ok = (rsp_cnt != base);
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) tick();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset cmd_ready got=%b want=1", cmd_ready); end
        total++; if (TX_D_VLD !== 1'b0) begin bad++; $display("FAIL reset TX_D_VLD got=%b want=0", TX_D_VLD); end
        total++; if (TX_P_Data !== 8'h00) begin bad++; $display("FAIL reset TX_P_Data got=%h want=00", TX_P_Data); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset rsp_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_data !== 16'h0) begin bad++; $display("FAIL reset rsp_data got=%h want=0000", rsp_data); end
        total++; if (rsp_timeout !== 1'b0) begin bad++; $display("FAIL reset rsp_timeout got=%b want=0", rsp_timeout); end
        RST = 1'b1;
        tick();
    endtask

    task automatic test_reg_rd();
        logic [7:0] exp_tx[2];
        bit ok;
        int base;
        exp_tx[0] = 8'hBB; exp_tx[1] = 8'h02;
        tx_q.delete(); busy_len = 3; base = rsp_cnt;
        send_cmd(2'd1, 4'h2, 8'h00, 8'h00, 4'h0);
        wait_tx(2, ok);
        repeat (10) tick();
        rx_byte(8'h81);
        wait_rsp(base, 50, ok);
        repeat (2) tick();
        total++; if (!ok) begin bad++; $display("FAIL reg_rd rsp_valid not seen within 50 cycles"); end
        total++; if (rsp_cnt !== base + 1) begin bad++; $display("FAIL reg_rd pulses got=%0d want=1", rsp_cnt - base); end
        total++; if (tx_q.size() !== 2) begin bad++; $display("FAIL reg_rd tx count got=%0d want=2", tx_q.size()); end
        for (int i = 0; i < 2 && i < tx_q.size(); i++) begin
            total++; if (tx_q[i] !== exp_tx[i]) begin bad++; $display("FAIL reg_rd tx[%0d] got=%h want=%h", i, tx_q[i], exp_tx[i]); end
        end
        total++; if (rsp_d_cap !== 16'h0081) begin bad++; $display("FAIL reg_rd rsp_data got=%h want=0081", rsp_d_cap); end
        total++; if (rsp_to_cap !== 1'b0) begin bad++; $display("FAIL reg_rd rsp_timeout got=%b want=0", rsp_to_cap); end
    endtask

    task automatic test_alu_op();
        logic [7:0] exp_tx[4];
        bit ok;
        int base;
        exp_tx[0] = 8'hCC; exp_tx[1] = 8'hFF; exp_tx[2] = 8'h02; exp_tx[3] = 8'h00;
        tx_q.delete(); busy_len = 3; base = rsp_cnt;
        send_cmd(2'd2, 4'h0, 8'hFF, 8'h02, 4'h0);
        wait_tx(4, ok);
        repeat (10) tick();
        rx_byte(8'hFD);
        repeat (2) tick();
        rx_byte(8'h01);
        wait_rsp(base, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL alu_op rsp_valid not seen within 50 cycles"); end
        total++; if (tx_q.size() !== 4) begin bad++; $display("FAIL alu_op tx count got=%0d want=4", tx_q.size()); end
        for (int i = 0; i < 4 && i < tx_q.size(); i++) begin
            total++; if (tx_q[i] !== exp_tx[i]) begin bad++; $display("FAIL alu_op tx[%0d] got=%h want=%h", i, tx_q[i], exp_tx[i]); end
        end
        total++; if (rsp_d_cap !== 16'h01FD) begin bad++; $display("FAIL alu_op rsp_data got=%h want=01fd", rsp_d_cap); end
        total++; if (rsp_to_cap !== 1'b0) begin bad++; $display("FAIL alu_op rsp_timeout got=%b want=0", rsp_to_cap); end
    endtask

    task automatic test_reg_wr();
        logic [7:0] exp_tx[3];
        bit ok;
        int base;
        exp_tx[0] = 8'hAA; exp_tx[1] = 8'h05; exp_tx[2] = 8'h3C;
        tx_q.delete(); busy_len = 10; base = rsp_cnt;
        send_cmd(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0);
        wait_rsp(base, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL reg_wr rsp_valid not seen within 500 cycles"); end
        total++; if (tx_q.size() !== 3) begin bad++; $display("FAIL reg_wr tx count got=%0d want=3", tx_q.size()); end
        for (int i = 0; i < 3 && i < tx_q.size(); i++) begin
            total++; if (tx_q[i] !== exp_tx[i]) begin bad++; $display("FAIL reg_wr tx[%0d] got=%h want=%h", i, tx_q[i], exp_tx[i]); end
        end
        total++; if (rsp_d_cap !== 16'h0000) begin bad++; $display("FAIL reg_wr rsp_data got=%h want=0000", rsp_d_cap); end
        total++; if (rsp_to_cap !== 1'b0) begin bad++; $display("FAIL reg_wr rsp_timeout got=%b want=0", rsp_to_cap); end
    endtask

    task automatic test_alu_nop_timeout();
        logic [7:0] exp_tx[2];
        bit ok;
        int base;
        exp_tx[0] = 8'hDD; exp_tx[1] = 8'h03;
        tx_q.delete(); busy_len = 3; base = rsp_cnt;
        send_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h3);
        wait_tx(2, ok);
        repeat (10) tick();
        rx_byte(8'h77);
        wait_rsp(base, 300, ok);
        total++; if (!ok) begin bad++; $display("FAIL nop_timeout rsp_valid not seen within 300 cycles"); end
        total++; if (rsp_cyc - rx_cyc !== 100) begin bad++; $display("FAIL nop_timeout latency got=%0d want=100", rsp_cyc - rx_cyc); end
        total++; if (rsp_to_cap !== 1'b1) begin bad++; $display("FAIL nop_timeout rsp_timeout got=%b want=1", rsp_to_cap); end
        total++; if (rsp_d_cap !== 16'h0077) begin bad++; $display("FAIL nop_timeout rsp_data got=%h want=0077", rsp_d_cap); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL nop_timeout cmd_ready got=%b want=1", cmd_ready); end
        for (int i = 0; i < 2 && i < tx_q.size(); i++) begin
            total++; if (tx_q[i] !== exp_tx[i]) begin bad++; $display("FAIL nop_timeout tx[%0d] got=%h want=%h", i, tx_q[i], exp_tx[i]); end
        end
    endtask

    task automatic test_busy_hold();
        logic [7:0] exp_tx[2];
        bit ok;
        int base;
        exp_tx[0] = 8'hBB; exp_tx[1] = 8'h07;
        tx_q.delete(); busy_len = 3; base = rsp_cnt;
        busy_force = 1;
        tick();
        send_cmd(2'd1, 4'h7, 8'h00, 8'h00, 4'h0);
        repeat (25) tick();
        rx_byte(8'hEE);
        repeat (24) tick();
        total++; if (tx_q.size() !== 0) begin bad++; $display("FAIL busy_hold strobes while busy got=%0d want=0", tx_q.size()); end
        busy_force = 0;
        wait_tx(2, ok);
        repeat (10) tick();
        rx_byte(8'h42);
        wait_rsp(base, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL busy_hold rsp_valid not seen within 50 cycles"); end
        total++; if (tx_q.size() !== 2) begin bad++; $display("FAIL busy_hold tx count got=%0d want=2", tx_q.size()); end
        for (int i = 0; i < 2 && i < tx_q.size(); i++) begin
            total++; if (tx_q[i] !== exp_tx[i]) begin bad++; $display("FAIL busy_hold tx[%0d] got=%h want=%h", i, tx_q[i], exp_tx[i]); end
        end
        total++; if (rsp_d_cap !== 16'h0042) begin bad++; $display("FAIL busy_hold rsp_data got=%h want=0042", rsp_d_cap); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_tx[2];
        bit ok;
        int base;
        exp_tx[0] = 8'hBB; exp_tx[1] = 8'h09;
        tx_q.delete(); busy_len = 3; base = rsp_cnt;
        send_cmd(2'd2, 4'h0, 8'h12, 8'h34, 4'h1);
        wait_tx(4, ok);
        repeat (10) tick();
        rx_byte(8'hAB);
        RST = 1'b0;
        tick();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_mid cmd_ready got=%b want=1", cmd_ready); end
        total++; if (TX_D_VLD !== 1'b0) begin bad++; $display("FAIL reset_mid TX_D_VLD got=%b want=0", TX_D_VLD); end
        total++; if (TX_P_Data !== 8'h00) begin bad++; $display("FAIL reset_mid TX_P_Data got=%h want=00", TX_P_Data); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_mid rsp_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_data !== 16'h0) begin bad++; $display("FAIL reset_mid rsp_data got=%h want=0000", rsp_data); end
        total++; if (rsp_timeout !== 1'b0) begin bad++; $display("FAIL reset_mid rsp_timeout got=%b want=0", rsp_timeout); end
        RST = 1'b1;
        tick();
        total++; if (rsp_cnt !== base) begin bad++; $display("FAIL reset_mid stray pulses got=%0d want=0", rsp_cnt - base); end
        tx_q.delete();
        send_cmd(2'd1, 4'h9, 8'h00, 8'h00, 4'h0);
        wait_tx(2, ok);
        repeat (10) tick();
        rx_byte(8'h5A);
        wait_rsp(base, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL reset_mid rsp_valid not seen within 50 cycles"); end
        for (int i = 0; i < 2 && i < tx_q.size(); i++) begin
            total++; if (tx_q[i] !== exp_tx[i]) begin bad++; $display("FAIL reset_mid tx[%0d] got=%h want=%h", i, tx_q[i], exp_tx[i]); end
        end
        total++; if (rsp_d_cap !== 16'h005A) begin bad++; $display("FAIL reset_mid rsp_data got=%h want=005a", rsp_d_cap); end
        total++; if (rsp_to_cap !== 1'b0) begin bad++; $display("FAIL reset_mid rsp_timeout got=%b want=0", rsp_to_cap); end
    endtask

    initial begin
        test_reset();
        test_reg_rd();
        test_alu_op();
        test_reg_wr();
        test_alu_nop_timeout();
        test_busy_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
